ysyx_22040127_memory: RTL

Memory-access pipeline stage sitting directly after execute and before writeback. It accepts the execute→memory bus through the valid/allowin handshake and issues load/store requests on a 64-bit data port. It sign- or zero-extends load data and passes CSR and writeback control to writeback on a 192-bit bus. It also exposes a forwarding tap for the decode stage.

---
 rtl/ysyx_22040127_memory.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040127_memory.sv
// Memory-access stage between execute and writeback: issues load/store requests, extends load data, forwards to decode.
// Latency: non-memory and accepted stores hand off the cycle after capture; loads hand off in the cycle rvalid arrives.
// Backpressure: valid/allowin toward execute, valid/ready on the data port, stalls while wb_allowin is low.
//
// Ports: clk/rst (sync, active-high); ex_to_mem_valid/mem_allowin/ex_to_mem_bus from execute;
// wb_allowin/mem_to_wb_valid/mem_to_wb_bus to writeback; mem_flush kills the held instruction;
// dmem_* is the 64-bit data port; mem_fwd_* is the decode forwarding tap; mem_misalign flags boundary-crossing accesses.
module ysyx_22040127_memory (
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_to_mem_valid,
    output logic         mem_allowin,
    input  logic [261:0] ex_to_mem_bus,
    input  logic         wb_allowin,
    output logic         mem_to_wb_valid,
    output logic [191:0] mem_to_wb_bus,
    input  logic         mem_flush,
    output logic         dmem_req_valid,
    input  logic         dmem_req_ready,
    output logic         dmem_wen,
    output logic [63:0]  dmem_addr,
    output logic [63:0]  dmem_wdata,
    output logic [7:0]   dmem_wstrb,
    input  logic         dmem_rvalid,
    input  logic [63:0]  dmem_rdata,
    output logic         mem_fwd_wen,
    output logic [4:0]   mem_fwd_rd,
    output logic         mem_fwd_ready,
    output logic [63:0]  mem_fwd_data,
    output logic         mem_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t         state;
    logic           mem_valid;
    logic [261:0]   bus_r;
    logic [63:0]    result_r;

    // access size in bytes from memop[1:0]
    function automatic logic [3:0] acc_size(input logic [1:0] sz);
        case (sz)
            2'b00:   acc_size = 4'd1;
            2'b01:   acc_size = 4'd2;
            2'b10:   acc_size = 4'd4;
            default: acc_size = 4'd8;
        endcase
    endfunction

    // incoming instruction, decoded for the capture decision
    logic       in_mem, in_mis;
    logic [3:0] in_size;
    assign in_mem  = ex_to_mem_bus[134] | ex_to_mem_bus[133];
    assign in_size = acc_size(ex_to_mem_bus[137:136]);
    assign in_mis  = in_mem & (({1'b0, ex_to_mem_bus[66:64]} + in_size) > 4'd8);

    // held instruction fields
    logic [2:0]  memop, off;
    logic        memwrite, memread, mis;
    logic [3:0]  size;
    logic [63:0] addr, alu_out, wdata;
    logic        unused_jalr;
    assign memop       = bus_r[138:136];
    assign memwrite    = bus_r[134];
    assign memread     = bus_r[133];
    assign addr        = bus_r[127:64];
    assign alu_out     = bus_r[127:64];
    assign wdata       = bus_r[63:0];
    assign off         = addr[2:0];
    assign size        = acc_size(memop[1:0]);
    assign mis         = (memread | memwrite) & (({1'b0, off} + size) > 4'd8);
    assign unused_jalr = bus_r[171];

    // load extension from the addressed byte lane
    logic [63:0] lane, ext;
    assign lane = dmem_rdata >> {off, 3'b000};
    always_comb begin
        ext = lane;
        case (memop)
            3'b000:  ext = {{56{lane[7]}},  lane[7:0]};
            3'b001:  ext = {{48{lane[15]}}, lane[15:0]};
            3'b010:  ext = {{32{lane[31]}}, lane[31:0]};
            3'b011:  ext = lane;
            3'b100:  ext = {56'd0, lane[7:0]};
            3'b101:  ext = {48'd0, lane[15:0]};
            3'b110:  ext = {32'd0, lane[31:0]};
            default: ext = lane;
        endcase
    end

    // in WAIT the live response is the result; afterwards the latched copy
    logic [63:0] result;
    always_comb begin
        result = alu_out;
        if (mis)
            result = 64'd0;
        else if (memread)
            result = (state == WAIT) ? ext : result_r;
    end

    logic mem_ready_go;
    always_comb begin
        mem_ready_go = 1'b0;
        case (state)
            IDLE: mem_ready_go = 1'b1;
            REQ:  mem_ready_go = memwrite & dmem_req_ready;
            WAIT: mem_ready_go = dmem_rvalid;
            DONE: mem_ready_go = 1'b1;
            default: mem_ready_go = 1'b0;
        endcase
    end

    // A flushed load still owns the port until its response drains.
    always_comb begin
        if (state == WAIT && !mem_valid)
            mem_allowin = dmem_rvalid;
        else
            mem_allowin = !mem_valid | (mem_ready_go & wb_allowin);
    end

    logic capture, handoff, kill;
    assign mem_to_wb_valid = mem_valid & mem_ready_go;
    assign capture         = ex_to_mem_valid & mem_allowin;
    assign handoff         = mem_to_wb_valid & wb_allowin;
    assign kill            = mem_flush & mem_valid;

    logic reg_wen_out;
    assign reg_wen_out   = bus_r[135] & !mis;
    assign mem_to_wb_bus = {bus_r[261:172], bus_r[170:139], reg_wen_out, bus_r[132:128], result};

    // data port, driven from held state so it is stable while stalled
    logic [7:0] strb;
    assign strb           = ((8'd1 << size) - 8'd1) << off;
    assign dmem_req_valid = (state == REQ);
    assign dmem_wen       = memwrite;
    assign dmem_addr      = {addr[63:3], 3'b000};
    assign dmem_wdata     = wdata << {off, 3'b000};
    assign dmem_wstrb     = memwrite ? strb : 8'd0;

    assign mem_fwd_wen   = mem_valid & reg_wen_out & (bus_r[132:128] != 5'd0);
    assign mem_fwd_rd    = bus_r[132:128];
    assign mem_fwd_data  = result;
    assign mem_fwd_ready = ((state == IDLE) & mem_valid & (!memread | mis))
                         | ((state == WAIT) & dmem_rvalid)
                         | (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            state        <= IDLE;
            bus_r        <= '0;
            result_r     <= 64'd0;
            mem_misalign <= 1'b0;
        end else begin
            mem_misalign <= capture & in_mis;

            if (mem_allowin)
                mem_valid <= ex_to_mem_valid;
            else if (mem_flush)
                mem_valid <= 1'b0;

            if (capture) begin
                bus_r <= ex_to_mem_bus;
            end else if (kill) begin
                bus_r[135]     <= 1'b0;
                bus_r[180:178] <= 3'b000;
            end

            if (state == WAIT && dmem_rvalid)
                result_r <= ext;

            // a new capture always decides the next state for its own instruction
            if (capture) begin
                state <= (in_mem && !in_mis) ? REQ : IDLE;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    REQ: begin
                        if (dmem_req_ready) begin
                            if (memwrite)
                                state <= (handoff || kill) ? IDLE : DONE;
                            else
                                state <= WAIT;
                        end else if (kill) begin
                            state <= IDLE;
                        end
                    end
                    WAIT: begin
                        if (dmem_rvalid)
                            state <= (!mem_valid || handoff || kill) ? IDLE : DONE;
                    end
                    DONE: begin
                        if (handoff || kill)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
